// File: rtl/rvtest_monitor_if.sv
// Bundles the hart-facing status inputs and the monitor result outputs.
// Parameters must match the rvtest_monitor instance using the interface.
//   halted    : per-hart halted indication (bit i = hart i)
//   a0        : per-hart x10 value, hart i at [i*XLEN +: XLEN]
//   core_rst_n: stretched active-low reset to the harts
//   done/pass/fail_mask/fail_code/timeout : test verdict, valid while done
//   cycles    : run cycles counted since core_rst_n release
// Modports: master = harts / environment side, slave = monitor side.
interface rvtest_monitor_if #(
  parameter int NHART = 1,
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [NHART-1:0]      halted;
  logic [NHART*XLEN-1:0] a0;
  logic                  core_rst_n;
  logic                  done;
  logic                  pass;
  logic [NHART-1:0]      fail_mask;
  logic [XLEN-1:0]       fail_code;
  logic                  timeout;
  logic [CNT_W-1:0]      cycles;

  modport master (
    output halted, a0,
    input  core_rst_n, done, pass, fail_mask, fail_code, timeout, cycles
  );

  modport slave (
    input  halted, a0,
    output core_rst_n, done, pass, fail_mask, fail_code, timeout, cycles
  );
endinterface

// File: rtl/rvtest_monitor.sv
// Test-completion monitor for NHART RISC-V harts.
// Holds the harts in reset for RST_CYCLES, then counts run cycles while
// latching each hart's a0 on its first halt. Once every hart has halted the
// captured values are checked (a0 == 0 means pass) and the verdict is frozen
// until rst_n.
// Ports: clk, rst_n (async, active-low), bus (rvtest_monitor_if.slave).
// Optional watchdog: define RVTEST_MONITOR_TIMEOUT_EN to end the run with
// timeout = 1 once cycles reaches TIMEOUT; otherwise timeout is always 0.

// Per-hart sticky halt flag and a0 capture.
module rvtest_hart_cap #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            halted,
  input  logic [XLEN-1:0] a0,
  output logic            flag,
  output logic            flag_nxt,
  output logic [XLEN-1:0] cap
);
  // Next-cycle flag value, so halts seen this cycle count toward "all halted".
  assign flag_nxt = flag | (en & halted);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= 1'b0;
      cap  <= '0;
    end else if (en && halted && !flag) begin
      flag <= 1'b1;
      cap  <= a0;
    end
  end
endmodule

module rvtest_monitor #(
  parameter int NHART      = 1,
  parameter int XLEN       = 32,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 100000,
  parameter int CNT_W      = 32
) (
  input logic             clk,
  input logic             rst_n,
  rvtest_monitor_if.slave bus
);
`ifdef RVTEST_MONITOR_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [7:0]       HOLD_END = 8'(RST_CYCLES - 1);

  typedef enum logic [1:0] {HOLD, RUN, CHECK, DONE} state_t;

  state_t                      state_q, state_d;
  logic [7:0]                  hold_cnt;
  logic [CNT_W-1:0]            cycles_q;
  logic                        done_q, pass_q, tmo_q;
  logic [NHART-1:0]            mask_q;
  logic [XLEN-1:0]             code_q;
  logic [NHART-1:0]            flag, flag_nxt, fail_vec;
  logic [NHART-1:0][XLEN-1:0]  cap;
  logic [XLEN-1:0]             code_sel;
  logic                        run, all_halt, wd_hit;

  assign run = (state_q == RUN);

  for (genvar i = 0; i < NHART; i++) begin : g_hart
    rvtest_hart_cap #(.XLEN(XLEN)) u_cap (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (run),
      .halted   (bus.halted[i]),
      .a0       (bus.a0[i*XLEN +: XLEN]),
      .flag     (flag[i]),
      .flag_nxt (flag_nxt[i]),
      .cap      (cap[i])
    );
    assign fail_vec[i] = |cap[i];
  end

  assign all_halt = &flag_nxt;
  // Halt completion has priority over the watchdog in the same cycle.
  assign wd_hit   = WD_EN && (cycles_q >= WD_LIMIT);

  // Lowest-index failing hart wins: scan high to low, last hit sticks.
  always_comb begin
    code_sel = '0;
    for (int i = NHART - 1; i >= 0; i--)
      if (fail_vec[i]) code_sel = cap[i];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD:    if (hold_cnt == HOLD_END) state_d = RUN;
      RUN:     if (all_halt) state_d = CHECK;
               else if (wd_hit) state_d = DONE;
      CHECK:   state_d = DONE;
      default: state_d = DONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HOLD;
      hold_cnt <= '0;
      cycles_q <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      tmo_q    <= 1'b0;
      mask_q   <= '0;
      code_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == HOLD) hold_cnt <= hold_cnt + 8'd1;
      if (run && cycles_q != '1) cycles_q <= cycles_q + 1'b1;
      if (state_q == CHECK) begin
        done_q <= 1'b1;
        pass_q <= ~|fail_vec;
        mask_q <= fail_vec;
        code_q <= code_sel;
        tmo_q  <= 1'b0;
      end else if (run && state_d == DONE) begin
        // Watchdog exit: harts that never halted are the failures.
        done_q <= 1'b1;
        pass_q <= 1'b0;
        mask_q <= ~flag_nxt;
        code_q <= '0;
        tmo_q  <= 1'b1;
      end
    end
  end

  assign bus.core_rst_n = (state_q != HOLD);
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.fail_mask  = mask_q;
  assign bus.fail_code  = code_q;
  assign bus.timeout    = tmo_q & WD_EN;
  assign bus.cycles     = cycles_q;
endmodule

// File: doc/rvtest_monitor.md
RVTEST_MONITOR -- requirements
Module: rvtest_monitor

Interface
REQ-001 Parameter NHART, default 1: number of harts monitored, range 1..8.
REQ-002 Parameter XLEN, default 32: width of each hart's x10 (a0) result value.
REQ-003 Parameter RST_CYCLES, default 2: core reset hold after rst_n release, range 1..255.
REQ-004 Parameter TIMEOUT, default 100000: run-cycle limit, range >=1.
REQ-005 Parameter CNT_W, default 32: width of the cycle counter.
REQ-006 clk  input  1  single clock, all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 halted  input  NHART  per-hart halted state indication (bit i = hart i).
REQ-009 a0  input  NHART*XLEN  per-hart x10 value, hart i at bits [i*XLEN +: XLEN].
REQ-010 core_rst_n  output  1  stretched active-low reset to the harts.
REQ-011 done  output  1  test finished, sticky.
REQ-012 pass  output  1  valid while done: all harts halted with a0 == 0.
REQ-013 fail_mask  output  NHART  valid while done: bit i set if hart i failed or never halted.
REQ-014 fail_code  output  XLEN  valid while done: latched a0 of the lowest-index failing hart, else 0.
REQ-015 timeout  output  1  valid while done: run ended by watchdog.
REQ-016 cycles  output  CNT_W  run cycles counted since core_rst_n release.

Function
REQ-017 States: HOLD, RUN, CHECK, DONE; HOLD entered on reset.
REQ-018 HOLD: core_rst_n = 0; hold counter increments each cycle; after RST_CYCLES cycles in HOLD -> RUN, core_rst_n = 1 from the first RUN cycle.
REQ-019 RUN: cycles increments by 1 each cycle and saturates at all-ones.
REQ-020 RUN: in the first cycle halted[i] is seen high, hart i's halt flag is set (sticky) and a0 slice i is captured; later a0 changes are ignored.
REQ-021 A halted[i] that deasserts after capture does not clear the flag.
REQ-022 RUN -> CHECK in the cycle after all NHART halt flags are set; halts seen in the same cycle count together.
REQ-023 CHECK, one cycle: fail_mask[i] = (captured a0[i] != 0); pass = (fail_mask == 0); fail_code per REQ-014; -> DONE.
REQ-024 DONE: done = 1; all result outputs and cycles are frozen; core_rst_n stays 1; exit only through rst_n.
REQ-025 halted inputs are ignored in HOLD and DONE.
REQ-026 done, pass, fail_mask, fail_code and timeout change only on the HOLD->... CHECK->DONE or RUN->DONE transition edge.

Reset
REQ-027 rst_n low: state = HOLD, core_rst_n = 0, done = 0, pass = 0, fail_mask = 0, fail_code = 0, timeout = 0, cycles = 0; halt flags, captures and hold counter cleared.
REQ-028 rst_n asserted in any state, including mid-RUN, forces the outputs in REQ-027 immediately; HOLD restarts in full after release.

Configuration
REQ-029 Macro RVTEST_MONITOR_TIMEOUT_EN.
REQ-030 Defined: in RUN, when cycles reaches TIMEOUT without all halt flags set, the next state is DONE with timeout = 1, pass = 0, fail_mask = ~halt flags, fail_code = 0.
REQ-031 Defined: if the last halt flag is set in the same cycle the limit is reached, the halt wins (-> CHECK, timeout = 0).
REQ-032 Not defined: there is no watchdog, timeout is tied to 0, and RUN is left only through CHECK.

Verification
REQ-033 NHART=1, RST_CYCLES=2: release rst_n, assert halted at cycle 10 with a0=0 -> core_rst_n rises 2 cycles after release; done 2 cycles after halt; pass=1, fail_mask=0.
REQ-034 NHART=1: halt with a0=0x7 -> done=1, pass=0, fail_mask=1, fail_code=0x7.
REQ-035 NHART=4: halts at cycles 5,9,9,20 with a0 = 0,0,0x5,0, and a0 changed after each halt -> CHECK after cycle 20; fail_mask=4'b0100, fail_code=0x5 (captured values used).
REQ-036 TIMEOUT_EN defined, TIMEOUT=50, NHART=2: only hart 0 halts -> done at the cycle after cycles reaches 50, timeout=1, fail_mask=2'b10; repeat with hart 1 halting on the limit cycle -> timeout=0.
REQ-037 Assert rst_n low mid-RUN after one of two harts has halted -> all outputs reset at once; after release the full HOLD sequence replays and the old halt flag is gone.
REQ-038 Macro undefined, no halts for 10^6 cycles -> done stays 0, timeout=0, cycles keeps counting.
